// File: rtl/decoder_pkg.sv
// Shared types, default widths and sign-magnitude <-> two's-complement helpers
// for the decoder MAC sequencer.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        BIAS,
        DONE
    } state_t;

    localparam int DEF_N_INPUT  = 2;
    localparam int DEF_M_OUTPUT = 9;
    localparam int DEF_BITSIZE  = 32;
    localparam int DEF_FRAC     = 27;

    // Conversions work on a fixed 64-bit container: callers place the sign in
    // the top bit and the zero-extended magnitude below it.
    localparam int CONV_W = 64;

    function automatic logic signed [CONV_W-1:0] sm_to_tc(input logic [CONV_W-1:0] sm);
        logic signed [CONV_W-1:0] mag;
        mag = {1'b0, sm[CONV_W-2:0]};
        return sm[CONV_W-1] ? -mag : mag;
    endfunction

    function automatic logic [CONV_W-1:0] tc_to_sm(input logic signed [CONV_W-1:0] v);
        logic [CONV_W-1:0] mag;
        mag = v[CONV_W-1] ? -v : v;
        return {v[CONV_W-1], mag[CONV_W-2:0]};
    endfunction

endpackage

// File: rtl/sm_mult.sv
// Combinational sign-magnitude multiply; the magnitude product is shifted right
// by FRAC (truncating toward zero) and returned in two's complement.
module sm_mult
    import decoder_pkg::*;
#(
    parameter int BITSIZE = DEF_BITSIZE,
    parameter int FRAC    = DEF_FRAC
) (
    input  logic [BITSIZE-1:0]          a,
    input  logic [BITSIZE-1:0]          b,
    output logic signed [2*BITSIZE-1:0] p
);

    logic [2*BITSIZE-3:0] mag_full;
    logic [2*BITSIZE-1:0] mag_shift;

    assign mag_full  = a[BITSIZE-2:0] * b[BITSIZE-2:0];
    assign mag_shift = (2*BITSIZE)'(mag_full >> FRAC);
    assign p         = (a[BITSIZE-1] ^ b[BITSIZE-1]) ? -$signed(mag_shift) : $signed(mag_shift);

endmodule

// File: rtl/decoder_mac_seq.sv
// Sequential decoder layer: out[j] = sat(sum_i z[i]*w[i][j] + b[j]), one product per cycle.
// Optional macro DECODER_RELU_EN clamps negative results to +0.
module decoder_mac_seq
    import decoder_pkg::*;
#(
    parameter int N_INPUT  = DEF_N_INPUT,
    parameter int M_OUTPUT = DEF_M_OUTPUT,
    parameter int BITSIZE  = DEF_BITSIZE,
    parameter int FRAC     = DEF_FRAC
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [N_INPUT*BITSIZE-1:0]           z,
    input  logic [N_INPUT*M_OUTPUT*BITSIZE-1:0]  w,
    input  logic [M_OUTPUT*BITSIZE-1:0]          b,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [M_OUTPUT*BITSIZE-1:0]          out,
    output logic                                 overflow
);

    localparam int ACCW = 2*BITSIZE + $clog2(N_INPUT+1);
    localparam int IW   = (N_INPUT  > 1) ? $clog2(N_INPUT)  : 1;
    localparam int JW   = (M_OUTPUT > 1) ? $clog2(M_OUTPUT) : 1;
    localparam logic signed [ACCW-1:0] MAX_MAG = ACCW'({(BITSIZE-1){1'b1}});

    state_t state, state_nxt;

    logic [N_INPUT*BITSIZE-1:0]          z_q;
    logic [N_INPUT*M_OUTPUT*BITSIZE-1:0] w_q;
    logic [M_OUTPUT*BITSIZE-1:0]         b_q;
    logic [M_OUTPUT*BITSIZE-1:0]         out_q;
    logic                                ovf_q;
    logic signed [ACCW-1:0]              acc;
    logic [IW-1:0]                       i_q;
    logic [JW-1:0]                       j_q;

    logic [BITSIZE-1:0]          z_sel, w_sel, b_sel;
    logic signed [2*BITSIZE-1:0] prod;
    logic signed [CONV_W-1:0]    b_tc;
    logic signed [ACCW-1:0]      sum;
    logic [CONV_W-1:0]           sm_full;
    logic [BITSIZE-1:0]          word;
    logic                        sat;
    logic                        last_i, last_j;

    assign z_sel  = z_q[i_q*BITSIZE +: BITSIZE];
    assign w_sel  = w_q[(j_q*N_INPUT + i_q)*BITSIZE +: BITSIZE];
    assign b_sel  = b_q[j_q*BITSIZE +: BITSIZE];
    assign last_i = (i_q == IW'(N_INPUT-1));
    assign last_j = (j_q == JW'(M_OUTPUT-1));

    sm_mult #(
        .BITSIZE (BITSIZE),
        .FRAC    (FRAC)
    ) u_mult (
        .a (z_sel),
        .b (w_sel),
        .p (prod)
    );

    assign b_tc = sm_to_tc({b_sel[BITSIZE-1], (CONV_W-1)'(b_sel[BITSIZE-2:0])});
    assign sum  = acc + ACCW'(b_tc);

    // Saturate the biased sum and pack it back to sign-magnitude; zero comes out as +0.
    always_comb begin
        sat     = 1'b0;
        sm_full = tc_to_sm(CONV_W'(sum));
        word    = {sm_full[CONV_W-1], sm_full[BITSIZE-2:0]};
        if (sum > MAX_MAG) begin
            sat  = 1'b1;
            word = {1'b0, {(BITSIZE-1){1'b1}}};
        end else if (sum < -MAX_MAG) begin
            sat  = 1'b1;
            word = '1;
        end
`ifdef DECODER_RELU_EN
        if (word[BITSIZE-1]) begin
            word = '0;
        end
`else
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)  state_nxt = MAC;
            MAC:  if (last_i)    state_nxt = BIAS;
            BIAS: state_nxt = last_j ? DONE : MAC;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, accumulator and output word writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q   <= '0;
            w_q   <= '0;
            b_q   <= '0;
            out_q <= '0;
            ovf_q <= 1'b0;
            acc   <= '0;
            i_q   <= '0;
            j_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        z_q   <= z;
                        w_q   <= w;
                        b_q   <= b;
                        ovf_q <= 1'b0;
                        acc   <= '0;
                        i_q   <= '0;
                        j_q   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + ACCW'(prod);
                    i_q <= last_i ? '0 : i_q + IW'(1);
                end
                BIAS: begin
                    out_q[j_q*BITSIZE +: BITSIZE] <= word;
                    ovf_q <= ovf_q | sat;
                    acc   <= '0;
                    if (!last_j) begin
                        j_q <= j_q + JW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out       = out_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_decoder_mac_seq.sv
// Randomized and directed bench for decoder_mac_seq against an integer-arithmetic model.
module tb_decoder_mac_seq;

    localparam int N    = 2;
    localparam int M    = 9;
    localparam int B    = 32;
    localparam int FRAC = 27;
    localparam int VW   = M*B;
    localparam longint MAXV = (64'sd1 <<< (B-1)) - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N*B-1:0] z;
    logic [N*M*B-1:0] w;
    logic [M*B-1:0] b;
    logic           out_valid;
    logic           out_ready;
    logic [M*B-1:0] out;
    logic           overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decoder_mac_seq #(
        .N_INPUT  (N),
        .M_OUTPUT (M),
        .BITSIZE  (B),
        .FRAC     (FRAC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .w         (w),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .overflow  (overflow)
    );

    task automatic checkOutput(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint smToInt(input logic [B-1:0] x);
        longint mag;
        mag = longint'(x[B-2:0]);
        return x[B-1] ? -mag : mag;
    endfunction

    // Dot product per neuron with plain 64-bit integers, then saturate and repack.
    task automatic modelVector(input logic [N*B-1:0] zv, input logic [N*M*B-1:0] wv,
                               input logic [M*B-1:0] bv,
                               output logic [M*B-1:0] expOut, output logic expOvf);
        logic [B-1:0] zi, wij, word;
        longint acc, mag;
        expOut = '0;
        expOvf = 1'b0;
        for (int j = 0; j < M; j++) begin
            acc = 0;
            for (int i = 0; i < N; i++) begin
                zi  = zv[i*B +: B];
                wij = wv[(j*N+i)*B +: B];
                mag = (longint'(zi[B-2:0]) * longint'(wij[B-2:0])) >>> FRAC;
                acc = acc + ((zi[B-1] ^ wij[B-1]) ? -mag : mag);
            end
            acc = acc + smToInt(bv[j*B +: B]);
            if (acc > MAXV) begin
                word = {1'b0, {(B-1){1'b1}}};
                expOvf = 1'b1;
            end else if (acc < -MAXV) begin
                word = '1;
                expOvf = 1'b1;
            end else if (acc < 0) begin
                word = {1'b1, (B-1)'(-acc)};
            end else begin
                word = {1'b0, (B-1)'(acc)};
            end
`ifdef DECODER_RELU_EN
            if (word[B-1]) word = '0;
`else
`endif
            expOut[j*B +: B] = word;
        end
    endtask

    function automatic logic [B-1:0] randWord();
        logic [B-1:0] v;
        v = ($urandom & 32'h7FFF_FFFF) >> $urandom_range(0, 30);
        if ($urandom_range(0, 7) == 0) v = '0;
        v[B-1] = $urandom_range(0, 1) == 1;
        return v;
    endfunction

    task automatic applyStimulus(input string name, input logic [N*B-1:0] zv,
                                 input logic [N*M*B-1:0] wv, input logic [M*B-1:0] bv,
                                 input int hold);
        logic [M*B-1:0] expOut;
        logic expOvf;
        int cycles;
        modelVector(zv, wv, bv, expOut, expOvf);
        @(negedge clk);
        z = zv;
        w = wv;
        b = bv;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        checkOutput({name, ".in_ready_idle"}, VW'(in_ready), VW'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        z = {$urandom, $urandom};
        b[31:0] = $urandom;
        cycles = 0;
        while (!out_valid && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({name, ".latency"}, VW'(cycles), VW'(M*(N+1)));
        checkOutput({name, ".out"}, out, expOut);
        checkOutput({name, ".overflow"}, VW'(overflow), VW'(expOvf));
        repeat (hold) begin
            @(negedge clk);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            checkOutput({name, ".hold_valid"}, VW'(out_valid), VW'(1));
            checkOutput({name, ".hold_ready"}, VW'(in_ready), VW'(0));
            checkOutput({name, ".hold_out"}, out, expOut);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({name, ".back_to_idle"}, VW'({in_ready, out_valid}), VW'(2'b10));
        checkOutput({name, ".out_kept"}, out, expOut);
    endtask

    logic [N*B-1:0]   zv;
    logic [N*M*B-1:0] wv;
    logic [M*B-1:0]   bv;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        z = '0;
        w = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.in_ready", VW'(in_ready), VW'(1));
        checkOutput("reset.out_valid", VW'(out_valid), VW'(0));
        checkOutput("reset.out", out, '0);
        checkOutput("reset.overflow", VW'(overflow), VW'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Worked example: z[1]=1.0, z[0]=-0.5, neuron 0 gives 4.25.
        wv = '0;
        wv[31:0]  = 32'hBC00_0000;
        wv[63:32] = 32'h3C00_0000;
        bv = '0;
        bv[31:0]  = 32'hB800_0000;
        applyStimulus("example", {32'h0800_0000, 32'h8400_0000}, wv, bv, 20);
        checkOutput("example.word0", VW'(out[31:0]), VW'(32'h2200_0000));

        applyStimulus("sat_pos", {N{32'h7800_0000}}, {N*M{32'h7800_0000}}, '0, 1);
        checkOutput("sat_pos.words", out, {M{32'h7FFF_FFFF}});
        checkOutput("sat_pos.flag", VW'(overflow), VW'(1));

        applyStimulus("sat_neg", {N{32'hF800_0000}}, {N*M{32'h7800_0000}}, '0, 0);
`ifdef DECODER_RELU_EN
        checkOutput("sat_neg.words", out, '0);
`else
        checkOutput("sat_neg.words", out, {M{32'hFFFF_FFFF}});
`endif
        checkOutput("sat_neg.flag", VW'(overflow), VW'(1));

        applyStimulus("neg_zero", {32'h0000_0000, 32'h8000_0000}, {N*M{32'h0800_0000}}, '0, 0);
        checkOutput("neg_zero.words", out, '0);
        checkOutput("neg_zero.flag", VW'(overflow), VW'(0));

        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < N; k++) zv[k*B +: B] = randWord();
            for (int k = 0; k < N*M; k++) wv[k*B +: B] = randWord();
            for (int k = 0; k < M; k++) bv[k*B +: B] = randWord();
            applyStimulus($sformatf("rand%0d", t), zv, wv, bv, $urandom_range(0, 4));
        end

        // Load a nonzero result, then abort a transaction mid-MAC with reset.
        applyStimulus("preabort", {N{32'h7800_0000}}, {N*M{32'h7800_0000}}, '0, 0);
        @(negedge clk);
        z = {N{32'h0800_0000}};
        w = {N*M{32'h0800_0000}};
        b = '0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort.out_valid", VW'(out_valid), VW'(0));
        checkOutput("abort.out", out, '0);
        checkOutput("abort.overflow", VW'(overflow), VW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        wv = '0;
        wv[31:0]  = 32'hBC00_0000;
        wv[63:32] = 32'h3C00_0000;
        bv = '0;
        bv[31:0]  = 32'hB800_0000;
        applyStimulus("after_abort", {32'h0800_0000, 32'h8400_0000}, wv, bv, 2);
        checkOutput("after_abort.word0", VW'(out[31:0]), VW'(32'h2200_0000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder_mac_seq.md
DECODER_MAC_SEQ -- requirements
Module: decoder_mac_seq

Interface
REQ-001 Parameter N_INPUT, default 2, latent-vector length.
REQ-002 Parameter M_OUTPUT, default 9, output neuron count.
REQ-003 Parameter BITSIZE, default 32, word width, sign-magnitude (1 sign bit, BITSIZE-1-FRAC integer bits, FRAC fraction bits).
REQ-004 Parameter FRAC, default 27, fraction bits.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 Port clk, input, 1, sole clock; rising edge.
REQ-007 Port rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port in_valid, input, 1, z/w/b operands present.
REQ-009 Port in_ready, output, 1, block can accept operands.
REQ-010 Port z, input, N_INPUT*BITSIZE, z[i] at bits [(i+1)*BITSIZE-1 -: BITSIZE].
REQ-011 Port w, input, N_INPUT*M_OUTPUT*BITSIZE, w[i][j] at word index j*N_INPUT+i.
REQ-012 Port b, input, M_OUTPUT*BITSIZE, b[j] at word index j.
REQ-013 Port out_valid, output, 1, result vector present.
REQ-014 Port out_ready, input, 1, consumer accepts result.
REQ-015 Port out, output, M_OUTPUT*BITSIZE, out[j] at word index j, sign-magnitude.
REQ-016 Port overflow, output, 1, at least one out[j] saturated in the current result.

Function
REQ-017 States: IDLE, MAC, BIAS, DONE; in_ready SHALL be 1 only in IDLE.
REQ-018 On in_valid && in_ready, z/w/b SHALL be latched internally, j=0, i=0, acc=0, go to MAC.
REQ-019 MAC: one product per cycle, acc += z[i]*w[i][j] (signed, two's-complement internal, magnitude product shifted right FRAC bits, truncating toward zero); after i=N_INPUT-1 go to BIAS.
REQ-020 BIAS: acc+b[j], saturated, stored to out[j]; j<M_OUTPUT-1 -> MAC with i=0, acc=0; else -> DONE.
REQ-021 Accumulator width SHALL be 2*BITSIZE+clog2(N_INPUT+1) so no internal wrap occurs.
REQ-022 Saturation: |result| > 2^(BITSIZE-1)-1 LSBs SHALL clamp to sign | all-ones magnitude and set that word's overflow contribution.
REQ-023 A zero result SHALL be emitted as +0 (all zeros); -0 inputs SHALL be treated as 0.
REQ-024 Latency: out_valid SHALL rise exactly M_OUTPUT*(N_INPUT+1) cycles after the accept edge.
REQ-025 DONE: out_valid=1, out and overflow stable until out_valid && out_ready, then IDLE; in_valid during DONE SHALL be ignored.
REQ-026 out words SHALL not change outside BIAS-state writes; partial results are not visible as valid.

Reset
REQ-027 rst_n low SHALL force IDLE, in_ready=1 after release, out_valid=0, out=0, overflow=0, acc=0, counters=0, immediately and at any state, aborting any operation in progress.

Configuration
REQ-028 With DECODER_RELU_EN defined, any negative non-zero result SHALL be emitted as +0 after saturation (overflow still reports a saturated negative result); without it results pass signed.

Structure
REQ-029 Package decoder_pkg SHALL hold the state enum, default widths, and sign-magnitude<->two's-complement conversion functions.
REQ-030 One sub-module sm_mult SHALL implement the registered-free sign-magnitude multiply with FRAC alignment.

Verification
REQ-031 z={1.0,-0.5}, w[0][0]=-7.5, w[1][0]=7.5, b[0]=-7.0 -> out[0]=0x22000000 (4.25), out_valid at cycle 27 for N=2, M=9.
REQ-032 z all 15.0, w all 15.0, b=0 -> every out[j]=0x7FFFFFFF, overflow=1; same with z negative -> 0xFFFFFFFF (0 with DECODER_RELU_EN).
REQ-033 z[0]=0x80000000 (-0), all w=1.0, b=0 -> out all 0x00000000, overflow=0.
REQ-034 out_ready held low 20 cycles in DONE -> out, out_valid stable, in_ready=0; out_ready high -> IDLE next cycle.
REQ-035 rst_n pulsed low mid-MAC -> out_valid=0, out=0 immediately; next transaction yields correct REQ-031 result.
